// File: rtl/fetch_stage.sv
//==============================================================================
// Module      : fetch_stage
// Description : IF stage. Owns the PC, addresses instruction memory and loads
//               the IF/ID register under stall/flush/redirect/halt control.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [3:0]        HALT_OPC = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic                 r_valid;
    logic [ADDR_W-1:0]    r_id_pc;
    logic [INSTR_W-1:0]   r_id_instr;
    logic                 r_halted;

    logic [ADDR_W-1:0]    w_pc_inc;
    logic                 w_is_halt;

    // Modulo increment: the carry out is deliberately dropped.
    assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_is_halt = (imem_instr[INSTR_W-1 -: 4] == HALT_OPC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_id_pc    <= '0;
            r_id_instr <= '0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_valid <= 1'b0;
                    end else if (flush) begin
                        r_pc    <= w_pc_inc;
                        r_valid <= 1'b0;
                    end else if (!stall) begin
                        r_id_instr <= imem_instr;
                        r_id_pc    <= r_pc;
                        r_valid    <= 1'b1;
                        // The HALT word itself is delivered; the PC parks on it.
                        if (w_is_halt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end

                S_HALTED: begin
                    r_valid <= 1'b0;
                    if (redirect_valid) begin
                        r_pc     <= redirect_pc;
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_valid = r_valid;
    assign if_id_pc    = r_id_pc;
    assign if_id_instr = r_id_instr;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module      : tb_fetch_stage
// Description : Directed bench for fetch_stage with an expected-result queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [19:0] imem_instr;
    logic        if_id_valid;
    logic [7:0]  if_id_pc;
    logic [19:0] if_id_instr;
    logic        halted;

    logic [19:0] imem [0:255];

    typedef struct {
        logic        valid;
        logic [7:0]  pc;
        logic [19:0] instr;
        logic [7:0]  addr;
        logic        halted;
    } exp_t;

    exp_t q_exp[$];

    int n_checks;
    int n_fails;
    int n_step;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr];

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL step %0d %s observed=%h expected=%h", n_step, tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare.
    task automatic step(input logic rn, input logic st, input logic fl,
                        input logic rv, input logic [7:0] rpc,
                        input logic ev, input logic [7:0] epc, input logic [19:0] ein,
                        input logic [7:0] eaddr, input logic eh);
        exp_t e;
        @(negedge clk);
        rst_n          = rn;
        stall          = st;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e.valid = ev; e.pc = epc; e.instr = ein; e.addr = eaddr; e.halted = eh;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        n_step++;
        e = q_exp.pop_front();
        chk("valid",  {19'd0, if_id_valid}, {19'd0, e.valid});
        chk("pc",     {12'd0, if_id_pc},    {12'd0, e.pc});
        chk("instr",  if_id_instr,          e.instr);
        chk("addr",   {12'd0, imem_addr},   {12'd0, e.addr});
        chk("halted", {19'd0, halted},      {19'd0, e.halted});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        n_step   = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) imem[i] = 20'h00000;
        imem[0]     = 20'h00503;
        imem[1]     = 20'h00801;
        imem[2]     = 20'h10802;
        imem[3]     = 20'hF0000;
        imem[8'hFF] = 20'h00503;

        //   rn st fl rv rpc    v  pc     instr      addr   h
        // Reset, one IDLE cycle, then back-to-back fetch
        step(0, 0, 0, 0, 8'h00, 0, 8'h00, 20'h00000, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 20'h00000, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h01, 20'h00801, 8'h02, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h02, 20'h10802, 8'h03, 0);
        // Return to 0, then stall two cycles while pc=1
        step(1, 0, 0, 1, 8'h00, 0, 8'h02, 20'h10802, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        step(1, 1, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        step(1, 1, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h01, 20'h00801, 8'h02, 0);
        // Redirect together with stall at pc=2: redirect wins
        step(1, 1, 0, 1, 8'h00, 0, 8'h01, 20'h00801, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        // Flush at pc=1 skips 00801
        step(1, 0, 1, 0, 8'h00, 0, 8'h00, 20'h00503, 8'h02, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h02, 20'h10802, 8'h03, 0);
        // HALT capture, stall/flush ignored, redirect resumes
        step(1, 0, 0, 0, 8'h00, 1, 8'h03, 20'hF0000, 8'h03, 1);
        step(1, 1, 0, 0, 8'h00, 0, 8'h03, 20'hF0000, 8'h03, 1);
        step(1, 0, 1, 0, 8'h00, 0, 8'h03, 20'hF0000, 8'h03, 1);
        step(1, 0, 0, 0, 8'h00, 0, 8'h03, 20'hF0000, 8'h03, 1);
        step(1, 0, 0, 1, 8'h00, 0, 8'h03, 20'hF0000, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        // Redirect to FF, PC wraps to 00
        step(1, 0, 0, 1, 8'hFF, 0, 8'h00, 20'h00503, 8'hFF, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'hFF, 20'h00503, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h00, 20'h00503, 8'h01, 0);
        // Reset mid-run overrides simultaneous redirect
        step(0, 1, 1, 1, 8'h55, 0, 8'h00, 20'h00000, 8'h00, 0);
        // A stalled HALT word must not halt; reset out of HALTED
        step(1, 0, 0, 0, 8'h00, 0, 8'h00, 20'h00000, 8'h00, 0);
        step(1, 0, 0, 1, 8'h03, 0, 8'h00, 20'h00000, 8'h03, 0);
        step(1, 1, 0, 0, 8'h00, 0, 8'h00, 20'h00000, 8'h03, 0);
        step(1, 0, 0, 0, 8'h00, 1, 8'h03, 20'hF0000, 8'h03, 1);
        step(0, 0, 0, 0, 8'h00, 0, 8'h00, 20'h00000, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
